// File: rtl/fft_sequencer.sv
// fft_sequencer: issues stage/pair_id butterfly reads for the in-place radix-2 FFT and tags matching write-backs.
// Latency: first rd_en the cycle after start is taken; wr_en trails its rd_en by BF_LATENCY unstalled cycles.
// Backpressure: stall in ISSUE/DRAIN freezes state, counters and write delay line and masks rd_en/wr_en.
module fft_sequencer #(
   parameter int N          = 32,
   parameter int BF_LATENCY = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    stall,
   output logic [$clog2(N)-1:0]    stage,
   output logic [$clog2(N/2)-1:0]  pair_id,
   output logic                    rd_en,
   output logic                    wr_en,
   output logic [$clog2(N)-1:0]    wr_stage,
   output logic [$clog2(N/2)-1:0]  wr_pair_id,
   output logic                    busy,
   output logic                    done
);
   localparam int LOG2N = $clog2(N);
   localparam int SW    = $clog2(N);
   localparam int PW    = $clog2(N/2);
   localparam int CW    = $clog2(BF_LATENCY + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t        state, state_nxt;
   logic [SW-1:0] stage_nxt;
   logic [PW-1:0] pair_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          freeze;

   // Write-back delay line: slot 0 takes the current issue, last slot is the head.
   logic [BF_LATENCY-1:0] dl_vld;
   logic [SW-1:0]         dl_stage [BF_LATENCY];
   logic [PW-1:0]         dl_pair  [BF_LATENCY];

   assign busy   = (state == S_ISSUE) || (state == S_DRAIN);
   assign done   = (state == S_DONE);
   assign freeze = stall && busy;

   // State, stage/pair counters and drain counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         stage   <= '0;
         pair_id <= '0;
         cnt     <= '0;
      end else begin
         state   <= state_nxt;
         stage   <= stage_nxt;
         pair_id <= pair_nxt;
         cnt     <= cnt_nxt;
      end
   end

   // Next-state and read strobe; stage is checked against the last stage so it never wraps.
   always_comb begin
      state_nxt = state;
      stage_nxt = stage;
      pair_nxt  = pair_id;
      cnt_nxt   = cnt;
      rd_en     = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_ISSUE;
               stage_nxt = '0;
               pair_nxt  = '0;
            end
         end
         S_ISSUE: begin
            if (!stall) begin
               rd_en    = 1'b1;
               pair_nxt = pair_id + PW'(1);
               if (pair_id == PW'(N/2 - 1)) begin
                  state_nxt = S_DRAIN;
                  cnt_nxt   = CW'(BF_LATENCY);
               end
            end
         end
         S_DRAIN: begin
            if (!stall) begin
               cnt_nxt = cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  if (stage == SW'(LOG2N - 1)) begin
                     state_nxt = S_DONE;
                  end else begin
                     state_nxt = S_ISSUE;
                     stage_nxt = stage + SW'(1);
                     pair_nxt  = '0;
                  end
               end
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Delay line shifts only on unstalled cycles so tags stay aligned with their reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dl_vld <= '0;
         for (int i = 0; i < BF_LATENCY; i++) begin
            dl_stage[i] <= '0;
            dl_pair[i]  <= '0;
         end
      end else if (!freeze) begin
         dl_vld[0]   <= rd_en;
         dl_stage[0] <= stage;
         dl_pair[0]  <= pair_id;
         for (int i = 1; i < BF_LATENCY; i++) begin
            dl_vld[i]   <= dl_vld[i-1];
            dl_stage[i] <= dl_stage[i-1];
            dl_pair[i]  <= dl_pair[i-1];
         end
      end
   end

   assign wr_en      = dl_vld[BF_LATENCY-1] && !freeze;
   assign wr_stage   = dl_stage[BF_LATENCY-1];
   assign wr_pair_id = dl_pair[BF_LATENCY-1];

endmodule

// File: tb/tb_fft_sequencer.sv
// Bench for fft_sequencer: stall/start plans drive the DUT while an issue-index model predicts every cycle.
// Model: u counts unstalled busy cycles; u/SPAN is the stage, u%SPAN < N/2 means a read, u-L gives the write.
// All waits are bounded by a per-transform cycle limit and a global watchdog.
module tb_fft_sequencer;
   localparam int N     = 32;
   localparam int L     = 3;
   localparam int LOG2N = 5;
   localparam int SPAN  = N/2 + L;
   localparam int TOTAL = LOG2N * SPAN;
   localparam int MAXC  = 400;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       stall = 1'b0;
   logic [4:0] stage, wr_stage;
   logic [3:0] pair_id, wr_pair_id;
   logic       rd_en, wr_en, busy, done;

   int errors = 0;
   int checks = 0;
   bit stall_plan [MAXC];
   bit start_plan [MAXC];

   fft_sequencer #(.N(N), .BF_LATENCY(L)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
      .stage(stage), .pair_id(pair_id), .rd_en(rd_en), .wr_en(wr_en),
      .wr_stage(wr_stage), .wr_pair_id(wr_pair_id), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic clear_plans();
      for (int i = 0; i < MAXC; i++) begin
         stall_plan[i] = 1'b0;
         start_plan[i] = 1'b0;
      end
   endtask

   // One transform from E0 to the idle cycle after done, checked cycle by cycle.
   task automatic run_xform(input bit launch, input bit chain,
                            output int done_cyc, output int rd_cnt, output int wr_cnt, output int nstall);
      int u;
      bit fin, st, e_busy, e_done, e_rd, e_wr;
      logic [4:0] es;
      logic [3:0] ep;
      u = 0; fin = 0; done_cyc = -1; rd_cnt = 0; wr_cnt = 0; nstall = 0;
      if (launch) begin
         @(posedge clk); #1;
         start = 1'b1; stall = 1'b0;
      end
      for (int k = 1; k < MAXC && !fin; k++) begin
         @(posedge clk); #1;
         st    = stall_plan[k];
         stall = st;
         start = start_plan[k];
         e_busy = (u < TOTAL);
         e_done = !e_busy && (done_cyc < 0);
         if (!e_busy && !e_done) begin
            start = chain;
            fin   = 1;
         end
         e_rd = e_busy && !st && ((u % SPAN) < N/2);
         e_wr = e_busy && !st && (u >= L) && (((u - L) % SPAN) < N/2);
         #1;
         checks++;
         if (busy !== e_busy) begin errors++; $display("FAIL busy c%0d: got %b want %b", k, busy, e_busy); end
         checks++;
         if (done !== e_done) begin errors++; $display("FAIL done c%0d: got %b want %b", k, done, e_done); end
         checks++;
         if (rd_en !== e_rd) begin errors++; $display("FAIL rd_en c%0d: got %b want %b", k, rd_en, e_rd); end
         checks++;
         if (wr_en !== e_wr) begin errors++; $display("FAIL wr_en c%0d: got %b want %b", k, wr_en, e_wr); end
         if (e_busy && ((u % SPAN) < N/2)) begin
            es = 5'(u / SPAN); ep = 4'(u % SPAN);
            checks++;
            if (stage !== es || pair_id !== ep) begin
               errors++;
               $display("FAIL issue tag c%0d: got (%0d,%0d) want (%0d,%0d)", k, stage, pair_id, es, ep);
            end
         end
         if (e_busy && (u >= L) && (((u - L) % SPAN) < N/2)) begin
            es = 5'((u - L) / SPAN); ep = 4'((u - L) % SPAN);
            checks++;
            if (wr_stage !== es || wr_pair_id !== ep) begin
               errors++;
               $display("FAIL write tag c%0d: got (%0d,%0d) want (%0d,%0d)", k, wr_stage, wr_pair_id, es, ep);
            end
         end
         if (rd_en === 1'b1) rd_cnt++;
         if (wr_en === 1'b1) wr_cnt++;
         if (e_done) done_cyc = k;
         if (e_busy) begin
            if (st) nstall++;
            else u++;
         end
      end
      if (!fin) begin
         checks++; errors++;
         $display("FAIL transform timeout: got no completion within %0d cycles want done", MAXC);
      end
   endtask

   task automatic check_int(input string name, input int got, input int want);
      checks++;
      if (got !== want) begin errors++; $display("FAIL %s: got %0d want %0d", name, got, want); end
   endtask

   task automatic check_all_zero(input string name);
      checks++;
      if ({stage, pair_id, rd_en, wr_en, wr_stage, wr_pair_id, busy, done} !== '0) begin
         errors++;
         $display("FAIL %s: got stage=%0d pair=%0d rd=%b wr=%b wst=%0d wp=%0d busy=%b done=%b want all 0",
                  name, stage, pair_id, rd_en, wr_en, wr_stage, wr_pair_id, busy, done);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      check_all_zero("reset outputs");
      #10 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #2;
         checks++;
         if (busy !== 1'b0 || rd_en !== 1'b0) begin
            errors++; $display("FAIL idle after reset: got busy=%b rd=%b want 0 0", busy, rd_en);
         end
      end
   endtask

   task automatic test_nominal();
      int dc, rc, wc, ns;
      clear_plans();
      run_xform(1, 0, dc, rc, wc, ns);
      check_int("nominal done cycle", dc, 96);
      check_int("nominal rd count", rc, 80);
      check_int("nominal wr count", wc, 80);
   endtask

   task automatic test_stall_mid();
      int dc, rc, wc, ns;
      clear_plans();
      for (int k = 46; k <= 50; k++) stall_plan[k] = 1'b1;
      run_xform(1, 0, dc, rc, wc, ns);
      check_int("stall mid done cycle", dc, 101);
      check_int("stall mid rd count", rc, 80);
      check_int("stall mid wr count", wc, 80);
   endtask

   task automatic test_stall_final_drain();
      int dc, rc, wc, ns;
      clear_plans();
      for (int k = 94; k <= 97; k++) stall_plan[k] = 1'b1;
      run_xform(1, 0, dc, rc, wc, ns);
      check_int("final drain stall done cycle", dc, 100);
      check_int("final drain stall wr count", wc, 80);
   endtask

   task automatic test_random_stall();
      int dc, rc, wc, ns;
      for (int r = 0; r < 3; r++) begin
         clear_plans();
         for (int k = 1; k < MAXC; k++) stall_plan[k] = ($urandom_range(0, 5) == 0);
         run_xform(1, 0, dc, rc, wc, ns);
         check_int("random stall done cycle", dc, TOTAL + 1 + ns);
         check_int("random stall rd count", rc, 80);
         check_int("random stall wr count", wc, 80);
      end
      stall = 1'b0;
   endtask

   task automatic test_start_ignored();
      int dc, rc, wc, ns;
      clear_plans();
      for (int k = 1; k <= 96; k++) start_plan[k] = ($urandom_range(0, 2) == 0);
      start_plan[96] = 1'b1;
      run_xform(1, 0, dc, rc, wc, ns);
      check_int("start ignored done cycle", dc, 96);
      check_int("start ignored rd count", rc, 80);
      // Idle cycle after done had start low, so the block must stay idle.
      @(posedge clk); #2;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL stays idle: got busy=%b want 0", busy); end
   endtask

   task automatic test_back_to_back();
      int dc, rc, wc, ns;
      clear_plans();
      run_xform(1, 1, dc, rc, wc, ns);
      check_int("b2b first done cycle", dc, 96);
      run_xform(0, 0, dc, rc, wc, ns);
      check_int("b2b second done cycle", dc, 96);
      check_int("b2b second rd count", rc, 80);
   endtask

   task automatic test_reset_mid();
      int dc, rc, wc, ns;
      clear_plans();
      @(posedge clk); #1 start = 1'b1; stall = 1'b0;
      @(posedge clk); #1 start = 1'b0;
      repeat (64) @(posedge clk);
      #2;
      checks++;
      if (wr_en !== 1'b1 || stage !== 5'd3 || pair_id !== 4'd7) begin
         errors++;
         $display("FAIL pre-reset state: got wr=%b stage=%0d pair=%0d want 1 3 7", wr_en, stage, pair_id);
      end
      #2 rst_n = 1'b0;
      #1 check_all_zero("async reset mid stage 3");
      #3 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #2;
         checks++;
         if (busy !== 1'b0 || rd_en !== 1'b0 || wr_en !== 1'b0) begin
            errors++;
            $display("FAIL idle after mid reset: got busy=%b rd=%b wr=%b want 0 0 0", busy, rd_en, wr_en);
         end
      end
      run_xform(1, 0, dc, rc, wc, ns);
      check_int("post reset done cycle", dc, 96);
   endtask

   initial begin
      clear_plans();
      test_reset();
      test_nominal();
      test_stall_mid();
      test_stall_final_drain();
      test_random_stall();
      test_start_ignored();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
